// File: rtl/mem_port_arbiter.sv
// Two-source round-robin arbiter sharing one memory bridge port, one transaction in flight.
// Optional perf counters (grants per source, conflict cycles) when MEM_ARB_PERF_CNT_EN is defined.
module mem_port_arbiter #(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 128
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    s0_req_valid,
  output logic                    s0_req_ready,
  input  logic                    s0_req_we,
  input  logic [ADDR_WIDTH-1:0]   s0_req_addr,
  input  logic [DATA_WIDTH-1:0]   s0_req_wdata,
  input  logic [DATA_WIDTH/8-1:0] s0_req_wmask,
  output logic                    s0_rsp_valid,
  output logic [DATA_WIDTH-1:0]   s0_rsp_rdata,
  input  logic                    s1_req_valid,
  output logic                    s1_req_ready,
  input  logic                    s1_req_we,
  input  logic [ADDR_WIDTH-1:0]   s1_req_addr,
  input  logic [DATA_WIDTH-1:0]   s1_req_wdata,
  input  logic [DATA_WIDTH/8-1:0] s1_req_wmask,
  output logic                    s1_rsp_valid,
  output logic [DATA_WIDTH-1:0]   s1_rsp_rdata,
  output logic                    m_req_valid,
  input  logic                    m_req_ready,
  output logic                    m_req_we,
  output logic [ADDR_WIDTH-1:0]   m_req_addr,
  output logic [DATA_WIDTH-1:0]   m_req_wdata,
  output logic [DATA_WIDTH/8-1:0] m_req_wmask,
  input  logic                    m_rsp_valid,
  input  logic [DATA_WIDTH-1:0]   m_rsp_rdata,
  output logic                    busy,
  output logic                    grant_id
`ifdef MEM_ARB_PERF_CNT_EN
  ,
  output logic [31:0]             perf_grant0,
  output logic [31:0]             perf_grant1,
  output logic [31:0]             perf_conflict
`endif
);

  localparam int MASK_W = DATA_WIDTH / 8;

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, RSP = 2'd2} state_t;

  typedef struct packed {
    logic                  we;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic [MASK_W-1:0]     wmask;
  } mreq_t;

  state_t state_q, state_d;
  mreq_t  mreq_q;
  logic   last_grant_q;
  logic   grant_id_q;
  logic   any_valid;
  logic   both_valid;
  logic   sel;
  logic   take;

  // Conflicts alternate away from the previous winner; a lone requester always wins.
  always_comb begin
    any_valid  = s0_req_valid | s1_req_valid;
    both_valid = s0_req_valid & s1_req_valid;
    sel        = both_valid ? ~last_grant_q : s1_req_valid;
    take       = rstn && (state_q == IDLE) && any_valid;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q      <= IDLE;
      mreq_q       <= '0;
      last_grant_q <= 1'b1;
      grant_id_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (take) begin
        mreq_q       <= sel ? {s1_req_we, s1_req_addr, s1_req_wdata, s1_req_wmask}
                            : {s0_req_we, s0_req_addr, s0_req_wdata, s0_req_wmask};
        grant_id_q   <= sel;
        last_grant_q <= sel;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    s0_req_ready = 1'b0;
    s1_req_ready = 1'b0;
    s0_rsp_valid = 1'b0;
    s1_rsp_valid = 1'b0;
    m_req_valid  = 1'b0;
    case (state_q)
      IDLE: begin
        s0_req_ready = take && !sel;
        s1_req_ready = take &&  sel;
        if (any_valid) state_d = REQ;
      end
      REQ: begin
        m_req_valid = rstn;
        if (m_req_ready) state_d = RSP;
      end
      RSP: begin
        // Writes complete here too: the bridge acks them through m_rsp_valid.
        s0_rsp_valid = rstn && m_rsp_valid && !grant_id_q;
        s1_rsp_valid = rstn && m_rsp_valid &&  grant_id_q;
        if (m_rsp_valid) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign s0_rsp_rdata = s0_rsp_valid ? m_rsp_rdata : '0;
  assign s1_rsp_rdata = s1_rsp_valid ? m_rsp_rdata : '0;
  assign m_req_we     = mreq_q.we;
  assign m_req_addr   = mreq_q.addr;
  assign m_req_wdata  = mreq_q.wdata;
  assign m_req_wmask  = mreq_q.wmask;
  assign busy         = rstn && (state_q != IDLE);
  assign grant_id     = grant_id_q;

`ifdef MEM_ARB_PERF_CNT_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  always_ff @(posedge clk) begin
    if (!rstn) begin
      perf_grant0   <= '0;
      perf_grant1   <= '0;
      perf_conflict <= '0;
    end else begin
      if (take && !sel) perf_grant0 <= sat_inc(perf_grant0);
      if (take &&  sel) perf_grant1 <= sat_inc(perf_grant1);
      if ((state_q == IDLE) && both_valid) perf_conflict <= sat_inc(perf_conflict);
    end
  end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: expected responses queued at request time, popped on rsp pulses.
module tb_mem_port_arbiter;
  localparam int AW = 64;
  localparam int DW = 128;
  localparam int MW = DW / 8;

  logic          clk = 1'b0;
  logic          rstn;
  logic          s0_req_valid, s0_req_ready, s0_req_we, s0_rsp_valid;
  logic [AW-1:0] s0_req_addr;
  logic [DW-1:0] s0_req_wdata, s0_rsp_rdata;
  logic [MW-1:0] s0_req_wmask;
  logic          s1_req_valid, s1_req_ready, s1_req_we, s1_rsp_valid;
  logic [AW-1:0] s1_req_addr;
  logic [DW-1:0] s1_req_wdata, s1_rsp_rdata;
  logic [MW-1:0] s1_req_wmask;
  logic          m_req_valid, m_req_ready, m_req_we, m_rsp_valid;
  logic [AW-1:0] m_req_addr;
  logic [DW-1:0] m_req_wdata, m_rsp_rdata;
  logic [MW-1:0] m_req_wmask;
  logic          busy, grant_id;
`ifdef MEM_ARB_PERF_CNT_EN
  logic [31:0]   perf_grant0, perf_grant1, perf_conflict;
`endif

  typedef struct {
    logic          src;
    logic [DW-1:0] rdata;
  } exp_t;
  exp_t sb_q[$];

  int chk_cnt  = 0;
  int pass_cnt = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rstn(rstn),
    .s0_req_valid(s0_req_valid), .s0_req_ready(s0_req_ready), .s0_req_we(s0_req_we),
    .s0_req_addr(s0_req_addr), .s0_req_wdata(s0_req_wdata), .s0_req_wmask(s0_req_wmask),
    .s0_rsp_valid(s0_rsp_valid), .s0_rsp_rdata(s0_rsp_rdata),
    .s1_req_valid(s1_req_valid), .s1_req_ready(s1_req_ready), .s1_req_we(s1_req_we),
    .s1_req_addr(s1_req_addr), .s1_req_wdata(s1_req_wdata), .s1_req_wmask(s1_req_wmask),
    .s1_rsp_valid(s1_rsp_valid), .s1_rsp_rdata(s1_rsp_rdata),
    .m_req_valid(m_req_valid), .m_req_ready(m_req_ready), .m_req_we(m_req_we),
    .m_req_addr(m_req_addr), .m_req_wdata(m_req_wdata), .m_req_wmask(m_req_wmask),
    .m_rsp_valid(m_rsp_valid), .m_rsp_rdata(m_rsp_rdata),
    .busy(busy), .grant_id(grant_id)
`ifdef MEM_ARB_PERF_CNT_EN
    , .perf_grant0(perf_grant0), .perf_grant1(perf_grant1), .perf_conflict(perf_conflict)
`endif
  );

  // Response monitor: every rsp pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (s0_rsp_valid || s1_rsp_valid) begin
      exp_t e;
      chk_cnt++;
      if (sb_q.size() == 0) begin
        $display("FAIL rsp_unexpected: got s0=%b s1=%b, required no response", s0_rsp_valid, s1_rsp_valid);
      end else begin
        e = sb_q.pop_front();
        if ({s1_rsp_valid, s0_rsp_valid} !== (e.src ? 2'b10 : 2'b01) ||
            (e.src ? s1_rsp_rdata : s0_rsp_rdata) !== e.rdata ||
            (e.src ? s0_rsp_rdata : s1_rsp_rdata) !== '0)
          $display("FAIL rsp_match: got v=%b%b rd0=%h rd1=%h, required src=%0d rdata=%h",
                   s1_rsp_valid, s0_rsp_valid, s0_rsp_rdata, s1_rsp_rdata, e.src, e.rdata);
        else pass_cnt++;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time exceeded, required completion");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic push_exp(input logic src, input logic [DW-1:0] rd);
    exp_t e;
    e.src = src; e.rdata = rd;
    sb_q.push_back(e);
  endtask

  // Bridge responder: optional ready stall, then ack with rsp after rsp_dly cycles.
  task automatic bridge(input int rdy_dly, input int rsp_dly, input logic [DW-1:0] rd);
    int n = 0;
    while (!m_req_valid && n < 50) begin step(); n++; end
    if (!m_req_valid) begin
      chk_cnt++;
      $display("FAIL bridge_timeout: got m_req_valid=0, required 1 within 50 cycles");
      return;
    end
    repeat (rdy_dly) step();
    m_req_ready = 1'b1; step(); m_req_ready = 1'b0;
    repeat (rsp_dly) step();
    m_rsp_valid = 1'b1; m_rsp_rdata = rd; step();
    m_rsp_valid = 1'b0; m_rsp_rdata = '0;
  endtask

  task automatic apply_reset();
    rstn = 1'b0; step(); step(); rstn = 1'b1;
  endtask

  task automatic test_reset();
    s0_req_valid = 1'b1; s1_req_valid = 1'b1; m_rsp_valid = 1'b1; m_req_ready = 1'b1;
    rstn = 1'b0; step(); step();
    @(negedge clk);
    chk_cnt++;
    if ({s0_req_ready, s1_req_ready, s0_rsp_valid, s1_rsp_valid} !== 4'b0)
      $display("FAIL reset_handshake: got %b, required 0000", {s0_req_ready, s1_req_ready, s0_rsp_valid, s1_rsp_valid});
    else pass_cnt++;
    chk_cnt++;
    if ({m_req_valid, busy, grant_id, m_req_we} !== 4'b0 || m_req_addr !== '0 || m_req_wdata !== '0 || m_req_wmask !== '0)
      $display("FAIL reset_master: got v/busy/gid/we=%b addr=%h, required all 0",
               {m_req_valid, busy, grant_id, m_req_we}, m_req_addr);
    else pass_cnt++;
    s0_req_valid = 1'b0; s1_req_valid = 1'b0; m_rsp_valid = 1'b0; m_req_ready = 1'b0;
    step(); rstn = 1'b1; step();
  endtask

  task automatic test_single_read();
    logic [DW-1:0] pat = {16{8'hA5}};
    s0_req_valid = 1'b1; s0_req_we = 1'b0; s0_req_addr = 64'h8000_0040;
    push_exp(1'b0, pat);
    m_req_ready = 1'b1;
    @(negedge clk);
    chk_cnt++;
    if ({s0_req_ready, s1_req_ready} !== 2'b10)
      $display("FAIL rd_ready: got s0=%b s1=%b, required s0=1 s1=0", s0_req_ready, s1_req_ready);
    else pass_cnt++;
    step(); s0_req_valid = 1'b0;
    @(negedge clk);
    chk_cnt++;
    if (m_req_valid !== 1'b1 || m_req_addr !== 64'h8000_0040 || m_req_we !== 1'b0 || grant_id !== 1'b0 || busy !== 1'b1)
      $display("FAIL rd_req: got v=%b addr=%h we=%b gid=%b busy=%b, required 1/80000040/0/0/1",
               m_req_valid, m_req_addr, m_req_we, grant_id, busy);
    else pass_cnt++;
    step(); m_req_ready = 1'b0;
    @(negedge clk);
    chk_cnt++;
    if (m_req_valid !== 1'b0)
      $display("FAIL rd_req_pulse: got m_req_valid=%b in second cycle, required 0", m_req_valid);
    else pass_cnt++;
    step();
    m_rsp_valid = 1'b1; m_rsp_rdata = pat;
    step(); m_rsp_valid = 1'b0; m_rsp_rdata = '0;
    @(negedge clk);
    chk_cnt++;
    if (busy !== 1'b0 || s0_rsp_valid !== 1'b0)
      $display("FAIL rd_done: got busy=%b s0_rsp_valid=%b, required 0/0", busy, s0_rsp_valid);
    else pass_cnt++;
    step();
  endtask

  task automatic test_round_robin();
    logic exp_src;
    apply_reset();
    s0_req_valid = 1'b1; s0_req_we = 1'b0; s0_req_addr = 64'h100;
    s1_req_valid = 1'b1; s1_req_we = 1'b0; s1_req_addr = 64'h200;
    for (int k = 0; k < 4; k++) begin
      exp_src = k[0];
      push_exp(exp_src, {8{16'h0 + 16'(k + 16'hC0)}});
      @(negedge clk);
      chk_cnt++;
      if ({s1_req_ready, s0_req_ready} !== (exp_src ? 2'b10 : 2'b01))
        $display("FAIL rr_ready_%0d: got s1/s0=%b%b, required source %0d", k, s1_req_ready, s0_req_ready, exp_src);
      else pass_cnt++;
      bridge(0, 1, {8{16'h0 + 16'(k + 16'hC0)}});
      if (k == 3) begin s0_req_valid = 1'b0; s1_req_valid = 1'b0; end
      chk_cnt++;
      if (grant_id !== exp_src)
        $display("FAIL rr_grant_%0d: got grant_id=%b, required %0d", k, grant_id, exp_src);
      else pass_cnt++;
    end
`ifdef MEM_ARB_PERF_CNT_EN
    chk_cnt++;
    if (perf_grant0 !== 32'd2 || perf_grant1 !== 32'd2 || perf_conflict < 32'd3)
      $display("FAIL perf_counts: got g0=%0d g1=%0d cf=%0d, required 2/2/>=3", perf_grant0, perf_grant1, perf_conflict);
    else pass_cnt++;
`endif
    step();
  endtask

  task automatic test_stall();
    logic [DW-1:0] wd = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_0F1E_2D3C;
    s0_req_valid = 1'b1; s0_req_we = 1'b1; s0_req_addr = 64'h8000_2000;
    s0_req_wdata = wd; s0_req_wmask = 16'h0F0F;
    push_exp(1'b0, 128'h55);
    step();
    // Scramble source fields after the grant; the latched copy must not move.
    s0_req_valid = 1'b0; s0_req_we = 1'b0; s0_req_addr = '1; s0_req_wdata = '0; s0_req_wmask = '0;
    s1_req_valid = 1'b1; s1_req_we = 1'b0; s1_req_addr = 64'h300;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk_cnt++;
      if (m_req_valid !== 1'b1 || m_req_we !== 1'b1 || m_req_addr !== 64'h8000_2000 ||
          m_req_wdata !== wd || m_req_wmask !== 16'h0F0F || s0_req_ready !== 1'b0 || s1_req_ready !== 1'b0)
        $display("FAIL stall_%0d: got v=%b we=%b addr=%h mask=%h rdy=%b%b, required 1/1/80002000/0f0f/00",
                 c, m_req_valid, m_req_we, m_req_addr, m_req_wmask, s1_req_ready, s0_req_ready);
      else pass_cnt++;
      step();
    end
    s1_req_valid = 1'b0;
    bridge(0, 0, 128'h55);
    step();
  endtask

  task automatic test_write_s1();
    logic [DW-1:0] wd = 128'h1122_3344_5566_7788_9900_AABB_CCDD_EEFF;
    s1_req_valid = 1'b1; s1_req_we = 1'b1; s1_req_addr = 64'h8000_1000;
    s1_req_wdata = wd; s1_req_wmask = 16'hFFFF;
    push_exp(1'b1, 128'h0);
    step(); s1_req_valid = 1'b0;
    @(negedge clk);
    chk_cnt++;
    if (m_req_valid !== 1'b1 || m_req_we !== 1'b1 || m_req_addr !== 64'h8000_1000 ||
        m_req_wdata !== wd || m_req_wmask !== 16'hFFFF || grant_id !== 1'b1)
      $display("FAIL wr_fields: got v=%b we=%b addr=%h wdata=%h mask=%h gid=%b, required 1/1/80001000/%h/ffff/1",
               m_req_valid, m_req_we, m_req_addr, m_req_wdata, m_req_wmask, grant_id, wd);
    else pass_cnt++;
    bridge(2, 1, 128'h0);
    step();
  endtask

  task automatic test_reset_in_rsp();
    s0_req_valid = 1'b1; s0_req_we = 1'b0; s0_req_addr = 64'h8000_0080;
    step(); s0_req_valid = 1'b0;
    m_req_ready = 1'b1; step(); m_req_ready = 1'b0;
    rstn = 1'b0; step(); rstn = 1'b1;
    m_rsp_valid = 1'b1; m_rsp_rdata = {8{16'hBAD0}};
    @(negedge clk);
    chk_cnt++;
    if (s0_rsp_valid !== 1'b0 || s1_rsp_valid !== 1'b0 || busy !== 1'b0)
      $display("FAIL rst_rsp_drop: got s0=%b s1=%b busy=%b, required 0/0/0", s0_rsp_valid, s1_rsp_valid, busy);
    else pass_cnt++;
    step(); m_rsp_valid = 1'b0; m_rsp_rdata = '0;
    s1_req_valid = 1'b1; s1_req_we = 1'b0; s1_req_addr = 64'h8000_0100;
    push_exp(1'b1, {4{32'h600D_F00D}});
    @(negedge clk);
    chk_cnt++;
    if (s1_req_ready !== 1'b1)
      $display("FAIL rst_regrant: got s1_req_ready=%b, required 1", s1_req_ready);
    else pass_cnt++;
    step(); s1_req_valid = 1'b0;
    bridge(1, 0, {4{32'h600D_F00D}});
    step();
  endtask

  initial begin
    rstn = 1'b0;
    s0_req_valid = 0; s0_req_we = 0; s0_req_addr = '0; s0_req_wdata = '0; s0_req_wmask = '0;
    s1_req_valid = 0; s1_req_we = 0; s1_req_addr = '0; s1_req_wdata = '0; s1_req_wmask = '0;
    m_req_ready = 0; m_rsp_valid = 0; m_rsp_rdata = '0;
    step();
    test_reset();
    test_single_read();
    test_round_robin();
    test_stall();
    test_write_s1();
    test_reset_in_rsp();
    repeat (3) step();
    chk_cnt++;
    if (sb_q.size() != 0)
      $display("FAIL sb_drain: got %0d outstanding responses, required 0", sb_q.size());
    else pass_cnt++;
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
